// File: rtl/csa_accum_pkg.sv
// ---------------------------------------------------------------------------
// csa_accum_pkg
// Purpose : Shared types, default sizing and helper function for the
//           carry-save accumulator (csa_accum_seq) and its 3:2 compressor.
// Contents: state_t   - controller state encoding (IDLE, ACC, RESOLVE, OUT)
//           DEF_*     - default block sizing
//           NCH       - carry-propagate chunks at default sizing
//           CNT_W     - operand-count width at default sizing
//           clog2()   - ceiling log2, usable in constant expressions
// ---------------------------------------------------------------------------
package csa_accum_pkg;

    // Ceiling log2. clog2(1) = 0, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    localparam int DEF_IN_W      = 16;
    localparam int DEF_N_MAX     = 16;
    localparam int DEF_ACC_W     = 20;
    localparam int DEF_CPA_CHUNK = 5;

    localparam int NCH   = DEF_ACC_W / DEF_CPA_CHUNK;
    localparam int CNT_W = clog2(DEF_N_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC     = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

endpackage

// File: rtl/csa_accum_seq_csa.sv
// ---------------------------------------------------------------------------
// csa_3to2_vec
// Purpose : W-bit bitwise 3:2 compressor (carry-save adder stage).
//           a + b + cin == s + cout (mod 2^W).
// Ports   : a, b, cin [W-1:0] in  - three addends
//           s         [W-1:0] out - bitwise sum (a ^ b ^ cin)
//           cout      [W-1:0] out - majority vector shifted left one place,
//                                   cout[0] = 0, top carry dropped
// ---------------------------------------------------------------------------
module csa_3to2_vec
    import csa_accum_pkg::*;
#(
    parameter int W = DEF_ACC_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] cin,
    output logic [W-1:0] s,
    output logic [W-1:0] cout
);

    logic [W-1:0] maj;

    // Each bit position is a full adder; the carries carry weight 2^(i+1),
    // so the majority vector is realigned by one place before leaving.
    always_comb begin
        s    = a ^ b ^ cin;
        maj  = (a & b) | (a & cin) | (b & cin);
        cout = {maj[W-2:0], 1'b0};
    end

endmodule

// File: rtl/csa_accum_seq.sv
// ---------------------------------------------------------------------------
// csa_accum_seq
// Purpose : Iterative multi-operand adder. Each accepted operand is folded
//           into a registered carry-save pair through one shared 3:2 stage;
//           the group total is then resolved CPA_CHUNK bits per cycle and
//           presented on a valid/ready output.
// Config  : CSA_ACCUM_SIGNED_EN - when defined, operands are two's complement
//           and sign-extended; otherwise they are zero-extended.
// Ports   : clk, rst                 - clock, synchronous active-high reset
//           in_valid/in_ready        - operand handshake
//           in_data [IN_W]           - operand
//           in_last                  - final operand of the group
//           out_valid/out_ready      - result handshake
//           out_data [ACC_W]         - group sum modulo 2^ACC_W
//           out_count                - operands accepted in the group
//           out_trunc                - group force-closed at N_MAX operands
//           busy                     - controller not idle
// ---------------------------------------------------------------------------
module csa_accum_seq
    import csa_accum_pkg::*;
#(
    parameter int IN_W      = DEF_IN_W,
    parameter int N_MAX     = DEF_N_MAX,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int CPA_CHUNK = DEF_CPA_CHUNK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [IN_W-1:0]             in_data,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic [clog2(N_MAX+1)-1:0]   out_count,
    output logic                        out_trunc,
    output logic                        busy
);

    localparam int NUM_CH = ACC_W / CPA_CHUNK;
    localparam int CW     = clog2(N_MAX + 1);
    localparam int KW     = (clog2(NUM_CH) > 0) ? clog2(NUM_CH) : 1;

    localparam logic [CW-1:0] COUNT_MAX = CW'(N_MAX);
    localparam logic [KW-1:0] K_LAST    = KW'(NUM_CH - 1);

    state_t              state;
    logic [ACC_W-1:0]    s_q;
    logic [ACC_W-1:0]    c_q;
    logic [ACC_W-1:0]    res_q;
    logic [ACC_W-1:0]    x;
    logic [ACC_W-1:0]    csa_s;
    logic [ACC_W-1:0]    csa_c;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_inc;
    logic [KW-1:0]       k_q;
    logic                trunc_q;
    logic                cy_q;
    logic                out_valid_q;
    logic                accept;
    logic                close_group;
    logic [CPA_CHUNK:0]  chunk_sum;

`ifdef CSA_ACCUM_SIGNED_EN
    assign x = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
`else
    assign x = {{(ACC_W-IN_W){1'b0}}, in_data};
`endif

    assign in_ready    = (state == IDLE) || (state == ACC);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;

    // count_q is zero whenever the controller is idle, so the same increment
    // and N_MAX test serve both the first beat and every later one.
    assign count_inc   = count_q + 1'b1;
    assign close_group = (count_inc == COUNT_MAX);

    assign out_valid   = out_valid_q;
    assign out_data    = res_q;
    assign out_count   = count_q;
    assign out_trunc   = trunc_q;

    csa_3to2_vec #(
        .W    (ACC_W)
    ) u_csa (
        .a    (s_q),
        .b    (c_q),
        .cin  (x),
        .s    (csa_s),
        .cout (csa_c)
    );

    // S and C shift right by one chunk per resolve cycle, so the chunk
    // being added always sits in the low bits and no variable index is needed.
    assign chunk_sum = {1'b0, s_q[CPA_CHUNK-1:0]}
                     + {1'b0, c_q[CPA_CHUNK-1:0]}
                     + {{CPA_CHUNK{1'b0}}, cy_q};

    // Controller and datapath registers. Resolved chunks enter res_q from the
    // top, so after NUM_CH cycles chunk 0 has reached the least significant
    // end. The first cycle in OUT loads the output stage; out_valid follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s_q         <= '0;
            c_q         <= '0;
            res_q       <= '0;
            count_q     <= '0;
            k_q         <= '0;
            trunc_q     <= 1'b0;
            cy_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        if (state == IDLE) begin
                            s_q <= x;
                            c_q <= '0;
                        end else begin
                            s_q <= csa_s;
                            c_q <= csa_c;
                        end
                        count_q <= count_inc;
                        trunc_q <= close_group && !in_last;
                        cy_q    <= 1'b0;
                        k_q     <= '0;
                        state   <= (in_last || close_group) ? RESOLVE : ACC;
                    end
                end
                RESOLVE: begin
                    res_q <= {chunk_sum[CPA_CHUNK-1:0], res_q[ACC_W-1:CPA_CHUNK]};
                    s_q   <= s_q >> CPA_CHUNK;
                    c_q   <= c_q >> CPA_CHUNK;
                    cy_q  <= chunk_sum[CPA_CHUNK];
                    k_q   <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_accum_seq
// Purpose : Self-checking bench for csa_accum_seq. Directed groups plus
//           randomized groups with random valid/ready stalls, compared with
//           a plain-arithmetic model of the group sum.
// Config  : honours CSA_ACCUM_SIGNED_EN for operand extension.
// ---------------------------------------------------------------------------
module tb_csa_accum_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_data;
    logic [4:0]  out_count;
    logic        out_trunc;
    logic        busy;

    int          checks;
    int          failures;
    int          cyc;
    logic [15:0] ops [0:31];

    csa_accum_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_trunc (out_trunc),
        .busy      (busy)
    );

    // 10 ns clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used to measure result latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Hard stop in case a wait loop were ever unbounded.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Operand as the adder sees it, widened to the accumulator width.
    function automatic logic [19:0] extend(input logic [15:0] v);
`ifdef CSA_ACCUM_SIGNED_EN
        return {{4{v[15]}}, v};
`else
        return {4'b0000, v};
`endif
    endfunction

    // Runs one group taken from ops[]. With setLast the n-th beat carries
    // in_last; otherwise beats keep coming and the group must close itself
    // after 16 operands. Ends at a negedge with the interface quiet.
    task automatic applyStimulus(input int n, input bit setLast, input int stallPct,
                                 input int readyWait, input bit useLit, input logic [19:0] litSum);
        int          expCount;
        bit          expTrunc;
        logic [19:0] expSum;
        logic [19:0] csSum;
        int          sent;
        int          budget;
        bit          acc;
        bit          seen;
        int          lastEdge;

        expCount = setLast ? n : 16;
        expTrunc = !setLast;
        expSum   = '0;
        for (int i = 0; i < expCount; i++) begin
            expSum = expSum + extend(ops[i]);
        end

        @(posedge clk);
        #1;
        sent   = 0;
        budget = 0;
        while (sent < expCount && budget < 400) begin
            in_valid  = ($urandom_range(0, 99) >= stallPct);
            in_data   = ops[sent];
            in_last   = setLast && (sent == n - 1);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent = sent + 1;
            budget = budget + 1;
        end
        if (sent < expCount) begin
            checkOutput("acceptTimeout", 32'(sent), 32'(expCount));
            rst = 1'b1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        // Hold the next beat on the bus; it must not be taken while busy.
        lastEdge = cyc;
        in_valid = 1'b1;
        in_data  = ops[sent];
        in_last  = 1'b0;
        @(negedge clk);
        checkOutput("inReadyBusy", 32'(in_ready), 32'd0);
        csSum = dut.s_q + dut.c_q;
        checkOutput("csInvariant", 32'(csSum), 32'(expSum));

        seen   = out_valid;
        budget = 0;
        while (!seen && budget < 30) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            budget = budget + 1;
            seen   = out_valid;
        end
        in_valid = 1'b0;
        if (!seen) begin
            checkOutput("outTimeout", 32'(out_valid), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            return;
        end

        checkOutput("latency", 32'(cyc - lastEdge), 32'd5);
        checkOutput("outData", 32'(out_data), 32'(expSum));
        if (useLit) checkOutput("outDataConst", 32'(out_data), 32'(litSum));
        checkOutput("outCount", 32'(out_count), 32'(expCount));
        checkOutput("outTrunc", 32'(out_trunc), 32'(expTrunc));

        out_ready = (readyWait == 0);
        for (int i = 0; i < readyWait; i++) begin
            @(negedge clk);
        end
        if (readyWait > 0) begin
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdData", 32'(out_data), 32'(expSum));
            checkOutput("holdCount", 32'(out_count), 32'(expCount));
            checkOutput("holdInReady", 32'(in_ready), 32'd0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("postValid", 32'(out_valid), 32'd0);
        checkOutput("postBusy", 32'(busy), 32'd0);
        checkOutput("postInReady", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [19:0] litVal;
        int          n;
        bit          setLast;

        checks    = 0;
        failures  = 0;
        cyc       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ops[i] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutData", 32'(out_data), 32'd0);
        checkOutput("rstOutCount", 32'(out_count), 32'd0);
        checkOutput("rstOutTrunc", 32'(out_trunc), 32'd0);

        // 1 + 2 + 3
        ops[0] = 16'd1; ops[1] = 16'd2; ops[2] = 16'd3;
        applyStimulus(3, 1'b1, 0, 0, 1'b1, 20'h00006);

        // Single full-scale operand
        ops[0] = 16'hFFFF;
`ifdef CSA_ACCUM_SIGNED_EN
        litVal = 20'hFFFFF;
`else
        litVal = 20'h0FFFF;
`endif
        applyStimulus(1, 1'b1, 0, 0, 1'b1, litVal);

        // 16 x 0xFFFF, closed by in_last, then force-closed at N_MAX
        for (int i = 0; i < 32; i++) ops[i] = 16'hFFFF;
        applyStimulus(16, 1'b1, 0, 0, 1'b1, 20'hFFFF0);
        applyStimulus(16, 1'b0, 0, 0, 1'b1, 20'hFFFF0);

        // Consumer holds off for 10 cycles
        ops[0] = 16'd1; ops[1] = 16'd2; ops[2] = 16'd3;
        applyStimulus(3, 1'b1, 0, 10, 1'b1, 20'h00006);

        // Reset in the middle of a group discards it
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i + 1);
            in_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstCount", 32'(out_count), 32'd0);
        ops[0] = 16'd7; ops[1] = 16'd8;
        applyStimulus(2, 1'b1, 0, 0, 1'b1, 20'h0000F);

        // Two full-scale operands: -2 when signed, 0x1FFFE when unsigned
        ops[0] = 16'hFFFF; ops[1] = 16'hFFFF;
`ifdef CSA_ACCUM_SIGNED_EN
        litVal = 20'hFFFFE;
`else
        litVal = 20'h1FFFE;
`endif
        applyStimulus(2, 1'b1, 0, 0, 1'b1, litVal);

        // Random groups with random stalls on both sides
        for (int g = 0; g < 30; g++) begin
            for (int i = 0; i < 32; i++) begin
                ops[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            n       = $urandom_range(1, 16);
            setLast = ($urandom_range(0, 3) != 0);
            applyStimulus(n, setLast, $urandom_range(0, 50), $urandom_range(0, 4), 1'b0, 20'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
